i2c_oled_target: RTL and testbench
==================================

# i2c_oled_target

I2C target (slave) responder for the OLED bring-up design. It is the bus-side counterpart of `i2c_master`. It decodes START/STOP, matches a 7-bit address, ACKs write bytes and hands each received byte to the fabric with a one-cycle strobe. It also serves read bytes from the fabric. It sits on the same `scl_bus`/`sda_bus` lines, either as an on-chip loopback target for master verification or as a display model in system benches.

## Interface
- `ADDR`, default 7'h3C: 7-bit target address matched after START.
- `CLK`  input  1: system clock (27 MHz nominal); all logic on rising edge.
- `RST`  input  1: asynchronous, active-high reset.
- `scl`  input  1: I2C clock from bus. No clock stretching; never driven.
- `sda`  inout  1: open-drain. Driven 0 when `sda_oe`=1, otherwise high-Z.
- `rx_data`  output  8: last received write byte (MSB first on bus).
- `rx_valid`  output  1: one-cycle pulse when `rx_data` updates.
- `rx_first`  output  1: high with `rx_valid` for the first data byte after the address (the control byte).
- `tx_data`  input  8: byte to send on reads; sampled on the `tx_req` cycle.
- `tx_req`  output  1: one-cycle pulse when `tx_data` is latched.
- `busy`  output  1: high from address match until STOP or repeated START.
- `start_det`, `stop_det`  output  1 each: one-cycle pulses on bus START/STOP.

## Operation
- `scl`/`sda` pass through 2-flop synchronizers plus one history flop. The block uses only synchronized levels and their edges.
- START = SDA 1→0 while SCL high. STOP = SDA 0→1 while SCL high. Either condition is recognized in every state and overrides the byte machine.
- Shift register: sample SDA on each SCL rising edge, MSB first. Bit counter 0..7, then ACK slot.
- States:
  - IDLE: `sda_oe`=0. START → ADDR.
  - ADDR: 8 bits collected (7 address + R/W).
    - Address equal to `ADDR` → ADDR_ACK.
    - Otherwise → IDLE (NACK, bus released).
  - ADDR_ACK: assert `sda_oe` on the SCL falling edge after bit 8, release it on the next falling edge, set `busy`. Then W → RX, R → TX.
  - RX: after 8 bits, pulse `rx_valid` (same CLK as the 8th-bit sample) and update `rx_data`; `rx_first` per the first-byte flag. → RX_ACK.
  - RX_ACK: drive ACK for one SCL period, as in ADDR_ACK. → RX.
  - TX: on entry, pulse `tx_req` and latch `tx_data`. Drive each bit on the SCL falling edge (`sda_oe` = ~bit). After 8 bits, release SDA → TX_ACK.
  - TX_ACK: sample the master's ACK on SCL rising. 0 → TX (next byte). 1 (NACK) → IDLE with SDA released; `busy` stays high until STOP/START.
- STOP: → IDLE, `sda_oe`=0, `busy`=0, `stop_det` pulses.
- Repeated START: → ADDR, `busy`=0, bit counter cleared, first-byte flag set.
- Reset mid-transfer: all state cleared, SDA released immediately (asynchronous). The block ignores the bus until the next START.

## Timing
- Reset values: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `rx_first`=0, `tx_req`=0, `busy`=0, `start_det`=0, `stop_det`=0, state IDLE.
- Bus-to-detect latency is 3 CLK from a pin edge to the internal edge pulse. Requirement: CLK ≥ 16× SCL, so 400 kHz is safe at 27 MHz.
- SDA changes only on the cycle after a detected SCL falling edge, giving hold ≥ 3 CLK after SCL low.
- `rx_valid` lands 3 CLK after the 8th SCL rising edge on the pin.
- `tx_data` must be stable on the `tx_req` cycle. The first bit is driven on the falling edge that ends the preceding ACK slot.

## Configuration
- `I2C_OLED_TARGET_READ_EN` defined: read path (TX, TX_ACK, `tx_req`, `tx_data` use) is compiled in.
- Not defined:
  - A matched address with R/W=1 is NACKed → IDLE.
  - `tx_req` is tied 0 and `tx_data` is ignored.
  - TX states are absent.

## Test plan
- Write 0x78, 0x00, 0xAE, STOP:
  - ACK on all three bytes.
  - `rx_valid` twice: 0x00 with `rx_first`=1, then 0xAE with `rx_first`=0.
  - `stop_det` pulses once; `busy` drops.
- Address 0x3D write (default `ADDR`): NACK (SDA never driven), no `rx_valid`, `busy` stays 0.
- Read 0x79 with `tx_data`=0xA5, master ACKs then NACKs:
  - Two `tx_req` pulses; bus shows 0xA5 twice.
  - SDA released after the NACK.
  - With the macro undefined: address NACKed.
- Write 0x78, 0x40, then repeated START with 0x78, 0x00, 0x11:
  - `start_det` pulses twice.
  - `rx_first`=1 on 0x40 and again on 0x00.
- `RST` asserted during the ACK slot of a data byte: SDA released within the same CLK (asynchronous). A following full write of 0x78, 0x00 completes normally.

Source files
------------

// File: rtl/i2c_oled_target.sv
// I2C target: START/STOP decode, 7-bit address match, write-byte ACK with
// rx strobe, optional read path (define I2C_OLED_TARGET_READ_EN).
// Ports: CLK, RST (async, high), scl in, sda open-drain inout,
// rx_data/rx_valid/rx_first, tx_data/tx_req, busy, start_det, stop_det.
module i2c_oled_target #(
  parameter logic [6:0] ADDR = 7'h3C
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX,
    S_RX_ACK
`ifdef I2C_OLED_TARGET_READ_EN
    ,
    S_TX,
    S_TX_ACK
`endif
  } state_t;

  state_t     state;
  logic       scl_s1, scl_s2, scl_h;
  logic       sda_s1, sda_s2, sda_h;
  logic       sda_oe;
  logic [7:0] sh;
  logic [2:0] bit_cnt;
  logic       ack_on;
  logic       first;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Sync flops reset high so a released bus never looks like an edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_h} <= {scl, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_h} <= {sda, sda_s1, sda_s2};
    end
  end

  logic       scl_hi, scl_rise, scl_fall;
  logic       start_ev, stop_ev;
  logic [7:0] sh_nx;
  logic       addr_ok;

  assign scl_hi   = scl_s2 & scl_h;
  assign scl_rise = scl_s2 & ~scl_h;
  assign scl_fall = ~scl_s2 & scl_h;
  assign start_ev = scl_hi & sda_h & ~sda_s2;
  assign stop_ev  = scl_hi & ~sda_h & sda_s2;
  assign sh_nx    = {sh[6:0], sda_s2};

`ifdef I2C_OLED_TARGET_READ_EN
  logic       rw;
  logic       done;
  logic [7:0] tx_sh;
  assign addr_ok = (sh_nx[7:1] == ADDR);
`else
  // Reads are NACKed when the read path is compiled out.
  logic unused_tx;
  assign unused_tx = ^tx_data;
  assign tx_req    = 1'b0;
  assign addr_ok   = (sh_nx[7:1] == ADDR) & ~sh_nx[0];
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      sda_oe    <= 1'b0;
      sh        <= 8'h00;
      bit_cnt   <= 3'd0;
      ack_on    <= 1'b0;
      first     <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_first  <= 1'b0;
      busy      <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
`ifdef I2C_OLED_TARGET_READ_EN
      rw        <= 1'b0;
      done      <= 1'b0;
      tx_sh     <= 8'h00;
      tx_req    <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      rx_first  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
`ifdef I2C_OLED_TARGET_READ_EN
      tx_req    <= 1'b0;
`endif
      if (start_ev) begin
        start_det <= 1'b1;
        state     <= S_ADDR;
        busy      <= 1'b0;
        bit_cnt   <= 3'd0;
        first     <= 1'b1;
        sda_oe    <= 1'b0;
        ack_on    <= 1'b0;
      end else if (stop_ev) begin
        stop_det <= 1'b1;
        state    <= S_IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_ADDR: begin
            if (scl_rise) begin
              sh      <= sh_nx;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (addr_ok) begin
                  state  <= S_ADDR_ACK;
                  busy   <= 1'b1;
                  ack_on <= 1'b0;
`ifdef I2C_OLED_TARGET_READ_EN
                  rw     <= sh_nx[0];
`endif
                end else begin
                  state <= S_IDLE;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= 3'd0;
`ifdef I2C_OLED_TARGET_READ_EN
                if (rw) begin
                  // Falling edge closing the ACK carries bit 7.
                  state  <= S_TX;
                  tx_req <= 1'b1;
                  done   <= 1'b0;
                  sda_oe <= ~tx_data[7];
                  tx_sh  <= {tx_data[6:0], 1'b0};
                end else begin
                  state  <= S_RX;
                  sda_oe <= 1'b0;
                end
`else
                state  <= S_RX;
                sda_oe <= 1'b0;
`endif
              end
            end
          end
          S_RX: begin
            if (scl_rise) begin
              sh      <= sh_nx;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= sh_nx;
                rx_valid <= 1'b1;
                rx_first <= first;
                first    <= 1'b0;
                ack_on   <= 1'b0;
                state    <= S_RX_ACK;
              end
            end
          end
          S_RX_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= S_RX;
              end
            end
          end
`ifdef I2C_OLED_TARGET_READ_EN
          S_TX: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) done <= 1'b1;
            end else if (scl_fall) begin
              if (done) begin
                sda_oe <= 1'b0;
                done   <= 1'b0;
                state  <= S_TX_ACK;
              end else begin
                sda_oe <= ~tx_sh[7];
                tx_sh  <= {tx_sh[6:0], 1'b0};
              end
            end
          end
          S_TX_ACK: begin
            if (scl_rise) begin
              if (!sda_s2) begin
                state   <= S_TX;
                tx_req  <= 1'b1;
                tx_sh   <= tx_data;
                bit_cnt <= 3'd0;
                done    <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_oled_target.sv
// Bench for i2c_oled_target: bit-banged I2C master, transaction-level
// model of expected rx bytes, ACKs and strobes.
module tb_i2c_oled_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] tx_data = 8'hA5;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first, tx_req;
  logic       busy, start_det, stop_det;
  wire        sda;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_oled_target dut (
    .CLK      (clk),
    .RST      (rst),
    .scl      (scl),
    .sda      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_first (rx_first),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  logic [8:0] rxq[$];
  int n_txreq = 0;
  int n_start = 0;
  int n_stop  = 0;
  int n_drv   = 0;

  always begin
    @(posedge clk);
    #2;
    if (rx_valid) rxq.push_back({rx_first, rx_data});
    if (tx_req) n_txreq++;
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (m_sda && sda === 1'b0) n_drv++;
  end

  int checks = 0;
  int errors = 0;
  logic [8:0] expq[$];
  logic [7:0] pay[$];
  int rx_rd = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c();
    m_sda = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    m_sda = 1'b0; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic stop_c();
    m_sda = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; tick(Q);
      scl = 1'b1;   tick(2 * Q);
      scl = 1'b0;   tick(Q);
    end
    m_sda = 1'b1;
  endtask

  task automatic ack_slot(output logic a);
    tick(Q);
    scl = 1'b1; tick(Q);
    a = sda;    tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    send_bits(b);
    ack_slot(a);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(Q);
      scl = 1'b1; tick(Q);
      b = {b[6:0], sda}; tick(Q);
      scl = 1'b0; tick(Q);
    end
    m_sda = mack; tick(Q);
    scl = 1'b1;   tick(2 * Q);
    scl = 1'b0;   tick(2);
    m_sda = 1'b1; tick(Q - 2);
  endtask

  // Model: the target ACKs only its own address in write mode; each
  // data byte of a matched write is delivered, the first one flagged.
  task automatic write_txn(string tag, logic [7:0] ab, bit do_stop);
    logic a;
    logic ea;
    ea = (ab[7:1] == 7'h3C && ab[0] == 1'b0) ? 1'b0 : 1'b1;
    start_c();
    write_byte(ab, a);
    chk({tag, "_addr_ack"}, a, ea);
    if (ea == 1'b0) begin
      for (int i = 0; i < pay.size(); i++) begin
        write_byte(pay[i], a);
        chk({tag, "_data_ack"}, a, 0);
        expq.push_back({(i == 0), pay[i]});
      end
    end
    if (do_stop) stop_c();
  endtask

  task automatic check_rx(string tag);
    tick(4);
    chk({tag, "_rx_count"}, rxq.size() - rx_rd, expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (rx_rd + i < rxq.size())
        chk({tag, "_rx_byte"}, rxq[rx_rd + i], expq[i]);
    rx_rd = rxq.size();
    expq.delete();
  endtask

  initial begin
    int s0, d0, t0;
    logic a;
    logic [7:0] b, v;

    tick(4);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_first", rx_first, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start_det", start_det, 0);
    chk("rst_stop_det", stop_det, 0);
    chk("rst_sda", sda, 1);
    rst = 1'b0;
    tick(4);

    s0 = n_stop;
    pay = '{8'h00, 8'hAE};
    write_txn("w1", 8'h78, 1'b0);
    chk("w1_busy_hi", busy, 1);
    stop_c();
    check_rx("w1");
    chk("w1_stop_cnt", n_stop - s0, 1);
    chk("w1_busy_lo", busy, 0);

    d0 = n_drv;
    pay = '{8'h55};
    write_txn("nack", 8'h7A, 1'b1);
    check_rx("nack");
    chk("nack_drv", n_drv - d0, 0);
    chk("nack_busy", busy, 0);

    t0 = n_txreq;
    tx_data = 8'hA5;
    start_c();
    write_byte(8'h79, a);
`ifdef I2C_OLED_TARGET_READ_EN
    chk("rd_addr_ack", a, 0);
    read_byte(1'b0, b);
    chk("rd_byte0", b, 8'hA5);
    read_byte(1'b1, b);
    chk("rd_byte1", b, 8'hA5);
    chk("rd_txreq_cnt", n_txreq - t0, 2);
    chk("rd_busy_hold", busy, 1);
    tick(Q);
    chk("rd_sda_rel", sda, 1);
    stop_c();
    chk("rd_busy_lo", busy, 0);
    for (int k = 0; k < 3; k++) begin
      v = 8'($urandom);
      tx_data = v;
      start_c();
      write_byte(8'h79, a);
      chk("rr_addr_ack", a, 0);
      read_byte(1'b1, b);
      chk("rr_byte", b, v);
      stop_c();
    end
`else
    chk("rd_addr_nack", a, 1);
    chk("rd_busy", busy, 0);
    chk("rd_txreq_cnt", n_txreq - t0, 0);
    stop_c();
`endif

    s0 = n_start;
    pay = '{8'h40};
    write_txn("rs1", 8'h78, 1'b0);
    pay = '{8'h00, 8'h11};
    write_txn("rs2", 8'h78, 1'b1);
    chk("rs_start_cnt", n_start - s0, 2);
    check_rx("rs");

    start_c();
    write_byte(8'h78, a);
    chk("ra_addr_ack", a, 0);
    send_bits(8'h5A);
    tick(Q);
    scl = 1'b1;
    tick(Q);
    chk("ra_ack_drv", sda, 0);
    rst = 1'b1;
    #1;
    chk("ra_sda_rel", sda, 1);
    chk("ra_busy", busy, 0);
    tick(Q);
    scl = 1'b0;
    tick(Q);
    rst = 1'b0;
    tick(Q);
    rx_rd = rxq.size();
    stop_c();
    pay = '{8'h00};
    write_txn("post", 8'h78, 1'b1);
    check_rx("post");

    for (int k = 0; k < 6; k++) begin
      logic [7:0] ab;
      int len;
      ab = ($urandom_range(0, 1) == 0) ? 8'h78 :
           {7'($urandom), 1'b0};
      len = $urandom_range(1, 3);
      pay.delete();
      for (int j = 0; j < len; j++) pay.push_back(8'($urandom));
      write_txn("rnd", ab, 1'b1);
      check_rx("rnd");
      chk("rnd_busy", busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
